// File: rtl/c3lib_rst_seq_pkg.sv
// Shared types and helpers for the reset release sequencer.
package c3lib_rst_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DELAY,
      WAIT_ACK,
      DONE,
      ERROR
   } seq_state_t;

   // Index width that stays at least one bit wide for a single-stage chain.
   function automatic int STAGE_IDX_W(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/c3lib_rst_seq_ctrl_sync.sv
// Two-flop synchronizer with asynchronous active-low clear.
module c3lib_rst_seq_ctrl_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic data_in,
   output logic data_out
);

   logic meta_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_reg <= 1'b0;
         data_out <= 1'b0;
      end else begin
         meta_reg <= data_in;
         data_out <= meta_reg;
      end
   end

endmodule

// File: rtl/c3lib_rst_seq_ctrl.sv
// Walks a chain of reset domains out of reset one at a time, waiting for a
// synchronized acknowledge from each domain before releasing the next.
module c3lib_rst_seq_ctrl
   import c3lib_rst_seq_pkg::*;
#(
   parameter int NUM_STAGES = 4,
   parameter int DLY_W      = 8,
   parameter int TO_W       = 12
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 seq_en,
   input  logic [NUM_STAGES*DLY_W-1:0]          dly_cfg,
   input  logic [TO_W-1:0]                      timeout_cfg,
   input  logic [NUM_STAGES-1:0]                stage_ack_async,
   output logic [NUM_STAGES-1:0]                stage_rst_n,
   output logic                                 seq_done,
   output logic                                 seq_err,
   output logic [STAGE_IDX_W(NUM_STAGES)-1:0]   err_stage
);

   localparam int IDX_W = STAGE_IDX_W(NUM_STAGES);
   localparam logic [IDX_W-1:0] LAST_STAGE = IDX_W'(NUM_STAGES - 1);

   seq_state_t        state_reg;
   logic [IDX_W-1:0]  k_reg;
   logic [DLY_W-1:0]  dly_cnt_reg;
   logic [TO_W-1:0]   to_cnt_reg;
   logic [TO_W-1:0]   to_shadow_reg;
   logic [DLY_W-1:0]  dly_shadow_reg [NUM_STAGES];

   logic [DLY_W-1:0]      dly_cfg_slice [NUM_STAGES];
   logic [NUM_STAGES-1:0] ack_sync;
   logic                  sync_rst_n;
   logic [IDX_W-1:0]      k_inc;
   logic                  ack_lost;
   logic [IDX_W-1:0]      lost_idx;

   assign sync_rst_n = ~rst;
   assign k_inc      = k_reg + IDX_W'(1);

   generate
      for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
         c3lib_rst_seq_ctrl_sync u_ack_sync (
            .clk      (clk),
            .rst_n    (sync_rst_n),
            .data_in  (stage_ack_async[gi]),
            .data_out (ack_sync[gi])
         );
         assign dly_cfg_slice[gi] = dly_cfg[gi*DLY_W +: DLY_W];
      end
   endgenerate

   // Lowest-numbered acknowledge that has dropped, for reporting in DONE.
   always_comb begin
      ack_lost = ~&ack_sync;
      lost_idx = '0;
      for (int i = NUM_STAGES - 1; i >= 0; i--) begin
         if (!ack_sync[i]) begin
            lost_idx = IDX_W'(i);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         k_reg         <= '0;
         dly_cnt_reg   <= '0;
         to_cnt_reg    <= '0;
         to_shadow_reg <= '0;
         for (int i = 0; i < NUM_STAGES; i++) begin
            dly_shadow_reg[i] <= '0;
         end
         stage_rst_n   <= '0;
         seq_done      <= 1'b0;
         seq_err       <= 1'b0;
         err_stage     <= '0;
      end else if (!seq_en && (state_reg != IDLE)) begin
         // Abort wins over every other transition.
         state_reg   <= IDLE;
         stage_rst_n <= '0;
         seq_done    <= 1'b0;
         seq_err     <= 1'b0;
         err_stage   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (seq_en) begin
                  for (int i = 0; i < NUM_STAGES; i++) begin
                     dly_shadow_reg[i] <= dly_cfg_slice[i];
                  end
                  to_shadow_reg <= timeout_cfg;
                  k_reg         <= '0;
                  dly_cnt_reg   <= dly_cfg_slice[0];
                  state_reg     <= DELAY;
               end
            end
            DELAY: begin
               if (dly_cnt_reg == '0) begin
                  stage_rst_n[k_reg] <= 1'b1;
                  to_cnt_reg         <= to_shadow_reg;
                  state_reg          <= WAIT_ACK;
               end else begin
                  dly_cnt_reg <= dly_cnt_reg - DLY_W'(1);
               end
            end
            WAIT_ACK: begin
               // An acknowledge on the timeout edge still counts as success.
               if (ack_sync[k_reg]) begin
                  if (k_reg == LAST_STAGE) begin
                     seq_done  <= 1'b1;
                     state_reg <= DONE;
                  end else begin
                     k_reg       <= k_inc;
                     dly_cnt_reg <= dly_shadow_reg[k_inc];
                     state_reg   <= DELAY;
                  end
               end else if (to_shadow_reg != '0) begin
                  if (to_cnt_reg == TO_W'(1)) begin
                     stage_rst_n <= '0;
                     seq_err     <= 1'b1;
                     err_stage   <= k_reg;
                     state_reg   <= ERROR;
                  end else begin
                     to_cnt_reg <= to_cnt_reg - TO_W'(1);
                  end
               end
            end
            DONE: begin
               if (ack_lost) begin
                  stage_rst_n <= '0;
                  seq_done    <= 1'b0;
                  seq_err     <= 1'b1;
                  err_stage   <= lost_idx;
                  state_reg   <= ERROR;
               end
            end
            ERROR: begin
               state_reg <= ERROR;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/c3lib_rst_seq_ctrl.md
# c3lib_rst_seq_ctrl

Reset release sequencer that walks an ordered chain of downstream reset domains out of reset, one stage at a time, with a programmable per-stage delay and a synchronized acknowledge from each domain before the next is released. It owns the active-low reset outputs feeding the AIB adapter and IO sub-blocks. It also owns the 2-stage clear-on-reset synchronizers on the returning acknowledges.

## Interface
- NUM_STAGES, 4, number of sequenced reset domains (1..16)
- DLY_W, 8, width of each per-stage release delay
- TO_W, 12, width of the acknowledge timeout
- clk  in  1  sequencer clock
- rst  in  1  asynchronous, active-high reset
- seq_en  in  1  level; 1 = run/hold sequence, 0 = abort/return all domains to reset
- dly_cfg  in  NUM_STAGES*DLY_W  delay before releasing stage k, in slice [k*DLY_W +: DLY_W]
- timeout_cfg  in  TO_W  max WAIT_ACK cycles per stage; 0 = no timeout
- stage_ack_async  in  NUM_STAGES  per-domain "out of reset" acknowledge, asynchronous to clk
- stage_rst_n  out  NUM_STAGES  active-low reset to each domain, registered
- seq_done  out  1  all stages released and acknowledged
- seq_err  out  1  sticky error (timeout or ack loss) until seq_en = 0
- err_stage  out  max(1,$clog2(NUM_STAGES))  stage index that caused seq_err

## Operation
- States: IDLE, DELAY, WAIT_ACK, DONE, ERROR. Stage index k, delay counter, timeout counter.
- IDLE: all stage_rst_n = 0. On seq_en = 1: capture dly_cfg and timeout_cfg into shadow registers, k = 0, load delay counter with dly[0], go DELAY. Config changes after capture are ignored until the next IDLE exit.
- DELAY: if counter == 0, set stage_rst_n[k] = 1, load timeout counter, go WAIT_ACK; else decrement.
- WAIT_ACK: on synced ack[k] = 1:
  - k == NUM_STAGES-1 → DONE.
  - Otherwise k++, load dly[k+1], go DELAY.
  - Else if timeout_cfg != 0 and T cycles have elapsed in WAIT_ACK → ERROR, err_stage = k.
  - Ack and timeout in the same cycle: ack wins.
- DONE: seq_done = 1. If any synced ack drops → ERROR, err_stage = lowest dropped index.
- ERROR: seq_err = 1, all stage_rst_n = 0. Hold until seq_en = 0.
- seq_en = 0 in any non-IDLE state → IDLE next edge. All stage_rst_n = 0, seq_done = 0, seq_err = 0, err_stage = 0 on that edge. Abort takes priority over every other transition.
- Acks are don't-care in IDLE. An ack already high when its stage is released is accepted after normal sync latency.
- Reset values (rst = 1, asynchronous): state IDLE, stage_rst_n all 0, seq_done 0, seq_err 0, err_stage 0, counters 0, synchronizer flops 0.

## Timing
- seq_en sampled 1 at edge E0 → stage_rst_n[0] rises at edge E0 + dly[0] + 1. Delay 0 releases one edge after DELAY entry.
- Ack path: 2-flop synchronizer. ack_async rising before edge A is visible to the FSM after edge A+1; the state transition occurs at edge A+2.
- Next stage release after ack-accept edge X: edge X + dly[k+1] + 1.
- Timeout: with timeout_cfg = T, ERROR is entered at the T-th edge after WAIT_ACK entry if no ack is seen.
- seq_done and seq_err are registered and assert on the same edge as the DONE or ERROR entry.
- stage_rst_n release is monotonic within one sequence: stage k never releases before stage k-1 is acknowledged.

## Structure
- Package c3lib_rst_seq_pkg holds:
  - state enum typedef (IDLE, DELAY, WAIT_ACK, DONE, ERROR).
  - STAGE_IDX_W helper function, max(1,$clog2(n)).
- Sub-module: NUM_STAGES instances of the library 2-stage clear-on-reset synchronizer primitive on stage_ack_async.
  - Driven by clk.
  - Its rst_n is driven by ~rst.
- FSM, counters and output registers live in the top module. No other sub-modules.

## Test plan
- Nominal run: NUM_STAGES = 4, dly = {3,0,5,1}, acks looped back from stage_rst_n. stage_rst_n[0] rises at E0+4; each later stage rises dly+1 edges after the previous ack accept plus 2-cycle sync. seq_done = 1 after ack[3] is accepted.
- Timeout: timeout_cfg = 10, ack[1] held 0. ERROR is entered 10 edges after stage 1 release: seq_err = 1, err_stage = 1, all stage_rst_n = 0. Dropping seq_en clears all of these the next edge.
- Ack/timeout race: timeout_cfg = 6, ack[0] timed so the synced ack arrives on the 6th WAIT_ACK edge. Sequence proceeds, seq_err stays 0.
- Abort mid-DELAY: seq_en falls during stage 2 DELAY. All stage_rst_n = 0 and state IDLE next edge. Re-assert seq_en with new dly_cfg; the new values are used.
- Ack loss in DONE: drop ack[2] and ack[3] together. seq_err = 1, err_stage = 2, all resets reasserted.
- Async reset: assert rst mid-WAIT_ACK between clock edges. All outputs go to 0 immediately. After rst release and seq_en = 1, the sequence restarts from stage 0.
